// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for an RV32-subset datapath.
// Latches the fetched instruction, decodes it, steps the datapath control lines one phase
// per cycle, counts retired instructions and parks in TRAP on anything it cannot execute.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [4:0]       status,
  output logic             pc_en,
  output logic             pcsrc,
  output logic             alusrc,
  output logic [3:0]       aluop,
  output logic             memrw,
  output logic             wb,
  output logic             regrw,
  output logic [1:0]       immgen_ctrl,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StTrap   = 3'b111
  } state_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSll = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0110;
  localparam logic [3:0] AluSra = 4'b0111;
  localparam logic [3:0] AluSlt = 4'b1000;

  localparam logic [1:0] ImmNone = 2'b00;
  localparam logic [1:0] ImmI    = 2'b01;
  localparam logic [1:0] ImmS    = 2'b10;
  localparam logic [1:0] ImmB    = 2'b11;

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;

  // Instruction fields of the latched word.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7_b5 = ir_q[30];

  // Register numbers and most immediate bits belong to the datapath, not to control.
  logic unused_bits;
  assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], instr[31], status[4], status[0]};

  logic is_r, is_i, is_lw, is_sw, is_b, is_legal;

  assign is_r     = (opcode == OpR);
  assign is_i     = (opcode == OpI);
  assign is_lw    = (opcode == OpLoad) && (funct3 == 3'b010);
  assign is_sw    = (opcode == OpStore) && (funct3 == 3'b010);
  assign is_b     = (opcode == OpBr);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_b;

  logic [3:0] alu_func;
  logic       alu_ok;

  // ALU function for register/immediate arithmetic; funct3 011 has no operation here.
  always_comb begin
    alu_func = AluAdd;
    alu_ok   = 1'b1;
    case (funct3)
      3'b000: alu_func = (is_r && funct7_b5) ? AluSub : AluAdd;
      3'b001: alu_func = AluSll;
      3'b010: alu_func = AluSlt;
      3'b011: alu_ok   = 1'b0;
      3'b100: alu_func = AluXor;
      3'b101: alu_func = funct7_b5 ? AluSra : AluSrl;
      3'b110: alu_func = AluOr;
      3'b111: alu_func = AluAnd;
      default: alu_ok  = 1'b0;
    endcase
  end

  logic br_taken;
  logic br_ok;

  // Branch condition from the live flags (Z, N, V); only the four supported compares are ok.
  always_comb begin
    br_taken = 1'b0;
    br_ok    = 1'b1;
    case (funct3)
      3'b000:  br_taken = status[3];
      3'b001:  br_taken = ~status[3];
      3'b100:  br_taken = status[2] ^ status[1];
      3'b101:  br_taken = ~(status[2] ^ status[1]);
      default: br_ok    = 1'b0;
    endcase
  end

  logic exec_ok;
  assign exec_ok = ((is_r | is_i) & alu_ok) | is_lw | is_sw | (is_b & br_ok);

  logic       ctl_alusrc;
  logic [3:0] ctl_aluop;
  logic [1:0] ctl_imm;

  // Operand, ALU and immediate selection; all zero for an instruction that is about to trap.
  always_comb begin
    ctl_alusrc = 1'b0;
    ctl_aluop  = AluAdd;
    ctl_imm    = ImmNone;
    if (exec_ok) begin
      if (is_r) begin
        ctl_aluop = alu_func;
      end else if (is_i) begin
        ctl_alusrc = 1'b1;
        ctl_imm    = ImmI;
        ctl_aluop  = alu_func;
      end else if (is_lw) begin
        ctl_alusrc = 1'b1;
        ctl_imm    = ImmI;
      end else if (is_sw) begin
        ctl_alusrc = 1'b1;
        ctl_imm    = ImmS;
      end else begin
        ctl_aluop = AluSub;
        ctl_imm   = ImmB;
      end
    end
  end

  logic pc_en_c, memrw_c, regrw_c;

  // Next-state and per-phase control outputs, decoded from state_q and ir_q only.
  always_comb begin
    state_d     = state_q;
    pc_en_c     = 1'b0;
    memrw_c     = 1'b0;
    regrw_c     = 1'b0;
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    aluop       = AluAdd;
    wb          = 1'b0;
    immgen_ctrl = ImmNone;
    trap        = 1'b0;
    unique case (state_q)
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        state_d = is_legal ? StExec : StTrap;
      end
      StExec: begin
        alusrc      = ctl_alusrc;
        aluop       = ctl_aluop;
        immgen_ctrl = ctl_imm;
        if (!exec_ok) begin
          state_d = StTrap;
        end else if (is_b) begin
          pc_en_c = 1'b1;
          pcsrc   = br_taken;
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alusrc      = ctl_alusrc;
        aluop       = ctl_aluop;
        immgen_ctrl = ctl_imm;
        if (is_sw) begin
          memrw_c = 1'b1;
          pc_en_c = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        alusrc      = ctl_alusrc;
        aluop       = ctl_aluop;
        immgen_ctrl = ctl_imm;
        regrw_c     = 1'b1;
        pc_en_c     = 1'b1;
        wb          = ~is_lw;
        state_d     = StFetch;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Write enables are suppressed while reset is asserted so an interrupted instruction
  // cannot commit anything on its way back to FETCH.
  assign pc_en   = pc_en_c & ~rst;
  assign memrw   = memrw_c & ~rst;
  assign regrw   = regrw_c & ~rst;
  assign state   = state_q;
  assign retired = retired_q;

  // State, instruction register and retire counter; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) begin
        ir_q <= instr;
      end
      if (pc_en_c) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32-subset datapath.
- Latches each fetched instruction and decodes it.
- Drives the datapath control lines (pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl) one phase per cycle, plus a PC write enable.
- Counts retired instructions and traps on illegal encodings.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps at 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction word from datapath; sampled only in FETCH
- status  in  5  datapath flags: [4]=P, [3]=Z, [2]=N, [1]=V, [0]=C
- pc_en  out  1  PC load enable; one pulse per retired instruction
- pcsrc  out  1  0 = PC+4, 1 = PC+imm
- alusrc  out  1  0 = rs2, 1 = immediate
- aluop  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000
- memrw  out  1  1 = RAM write
- wb  out  1  1 = ALU result to regfile, 0 = RAM data
- regrw  out  1  regfile write enable
- immgen_ctrl  out  2  00 none/R, 01 I, 10 S, 11 B
- state  out  3  FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 111
- trap  out  1  high while in TRAP
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset values:
  - state=FETCH; ir=0; retired=0.
  - pc_en, pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, trap all 0.
  - rst asserted in any state, including mid-instruction and TRAP: next state is FETCH, and no write enable (pc_en/regrw/memrw) is high in the reset cycle or the following cycle.
- Outputs are decoded only from the state register and ir. There is no combinational path from instr or status to outputs, except the branch pcsrc described below.
- FETCH: ir <= instr; next state DECODE.
- DECODE: classify ir[6:0].
  - 0110011 R, 0010011 I-ALU, 0000011 LW (funct3 010), 0100011 SW (funct3 010), 1100011 B.
  - Anything else → TRAP.
  - Otherwise → EXEC.
- EXEC: alusrc/immgen_ctrl/aluop held valid.
  - R: alusrc=0, immgen 00, aluop from {funct7[5],funct3}: ADD/SUB 000, SLL 001, SLT 010, XOR 100, SRL/SRA 101, OR 110, AND 111. funct3 011 → TRAP.
  - I-ALU: alusrc=1, immgen 01, same map; funct7[5] honoured only for funct3 101.
  - LW/SW: alusrc=1, aluop ADD, immgen 01 (LW) / 10 (SW).
  - B: alusrc=0, aluop SUB, immgen 11.
  - Next state: R/I → WB; LW/SW → MEM; B → FETCH, with pc_en=1 this cycle.
- Branch taken (combinational from status in EXEC only):
  - BEQ 000: Z.
  - BNE 001: !Z.
  - BLT 100: N^V.
  - BGE 101: !(N^V).
  - Other funct3 → TRAP, with no pc_en.
  - pcsrc=taken.
- MEM: ALU controls held as in EXEC.
  - SW: memrw=1, pc_en=1, next FETCH.
  - LW: memrw=0, next WB.
- WB: ALU controls held; regrw=1; pc_en=1; pcsrc=0; next FETCH.
  - R/I: wb=1.
  - LW: wb=0.
  - rd=0 still asserts regrw; the regfile ignores it.
- Latency per instruction: B=3, R/I=4, SW=4, LW=5 cycles.
- pcsrc=0 outside branch EXEC. memrw, regrw and pc_en are never high in FETCH, DECODE or TRAP.
- retired increments by 1 in every cycle with pc_en=1; it wraps from all-ones to 0.
- TRAP: trap=1, all enables 0, state held until rst.
- status[4] (P) and status[0] (C) are ignored.

Test Plan:
- Reset: rst high 2 cycles mid-EXEC of an ADD → state=000, all outputs 0, retired=0, no regrw pulse.
- R-type: instr=0x002081B3 (ADD x3,x1,x2) → states 000,001,010,100. In WB: regrw=1, wb=1, aluop=0000, alusrc=0, pc_en=1. retired=1.
- I-type and load: instr=0x00500093 (ADDI) then 0x0080A283 (LW x5,8(x1)).
  - ADDI: alusrc=1, immgen=01, 4 cycles.
  - LW: 5 cycles, memrw=0 throughout, WB with wb=0 and regrw=1.
  - retired=2.
- Store: instr=0x0050A623 (SW x5,12(x1)) → immgen=10, memrw=1 only in MEM, pc_en in MEM, regrw never high, 4 cycles.
- Branch: instr=0x00208463 (BEQ +8).
  - status[3]=1 → EXEC has pcsrc=1, pc_en=1, aluop=0001, immgen=11.
  - Repeat with status[3]=0 → pcsrc=0.
  - 3 cycles each.
- Illegal/wrap:
  - instr=0xFFFFFFFF → TRAP at cycle 3, trap=1, held for 10 cycles with no enables; rst recovers.
  - With CNT_W=2, 5 ADDs → retired=1.
